io_uart: RTL and testbench
==========================

// Module: io_uart
// PURPOSE
// Memory-mapped 8N1 UART on the I/O window of the memory stage (RAM address high byte 0xFE).
// Consumes the I/O select/address/strobes and the CPU write data; drives read data back onto the
// CPU bus through an active-low output enable. Buffers TX and RX bytes in small FIFOs.
// PARAMETERS
// CLK_DIV     16   i_clk cycles per serial bit (>=4); baud = f_clk / CLK_DIV
// FIFO_DEPTH  4    entries per TX and RX FIFO; power of two, >=2
// BASE_ADDR   8'h00  I/O address of DATA register; STATUS = BASE_ADDR+1
// PORTS
// i_clk        in   1  system clock
// i_reset      in   1  synchronous, active-high reset
// i_ioSelect   in   1  high when the current RAM access targets the I/O window
// i_ioAddress  in   8  I/O register address (RAM address low byte)
// i_ioNOE      in   1  active-low read strobe
// i_ioNWE      in   1  active-low write strobe
// i_data       in   8  CPU bus write data
// o_data       out  8  register read data (valid while o_dataNOE low)
// o_dataNOE    out  1  low when this block drives the bus
// i_rx         in   1  serial input, idle high, asynchronous
// o_tx         out  1  serial output, idle high
// o_irqN       out  1  low while RX FIFO not empty
// BEHAVIOUR
// - Access decode: hit = i_ioSelect & addr in {BASE_ADDR, BASE_ADDR+1}. Read = hit & !i_ioNOE;
//   write = hit & !i_ioNWE. Both sampled on posedge i_clk; read and write together: write wins, no pop.
// - o_dataNOE = !(read) combinationally; o_data = RX head (DATA) or STATUS; 8'h00 when not driving.
// - DATA write: push i_data to TX FIFO; if full, byte dropped, TX overflow flag set (sticky).
// - DATA read: o_data = RX head; FIFO pops on the posedge the read is sampled. Empty: returns 8'h00, no pop.
// - STATUS bits: [0] rx not empty, [1] tx not full, [2] rx overrun, [3] tx overflow, [4] tx idle
//   (FIFO empty and shifter IDLE), [7:5] 0. Reading STATUS clears [2] and [3] on that posedge;
//   a set event in the same cycle wins over the clear.
// - TX FSM: IDLE -> START (o_tx=0, CLK_DIV cycles) -> DATA (8 bits LSB first, CLK_DIV each) -> STOP
//   (o_tx=1, CLK_DIV) -> IDLE or directly START if FIFO non-empty. Pops FIFO on IDLE/STOP->START.
//   First start bit begins 1 cycle after the write is sampled.
// - RX: i_rx through 2-flop synchroniser. IDLE -> on synced 0, START: sample at CLK_DIV/2; if 1,
//   back to IDLE (glitch). DATA: sample every CLK_DIV, LSB first. STOP: sample; if 1 push byte,
//   if 0 drop byte (framing error, no flag). Push on full RX FIFO: byte dropped, overrun set.
// - Simultaneous push and pop on a full or empty FIFO: both performed when legal (pop on full frees
//   space for push; push on empty then pop does not see the new byte that cycle).
// - Counters: bit-time counter $clog2(CLK_DIV) bits, bit index 3 bits, FIFO pointers wrap modulo
//   FIFO_DEPTH with an extra bit for full/empty.
// - Reset (any cycle, incl. mid-frame): FIFOs empty, flags 0, both FSMs IDLE, o_tx=1, o_dataNOE=1,
//   o_data=0, o_irqN=1, synchroniser flops=1. A frame in progress is abandoned.
// STRUCTURE
// - Package io_pkg: register offsets (UART_DATA=0, UART_STATUS=1), STATUS bit indices, IO window
//   select value 8'hFE shared with memory stage.
// - One sub-module: sync_fifo (WIDTH, DEPTH; push/pop/full/empty/head), instanced for TX and RX.
// - TX and RX FSMs inline in io_uart.
// TESTING
// - Reset then write 8'hA5 to DATA (CLK_DIV=16) -> o_tx low at cycle+1 for 16 cycles, bits
//   1,0,1,0,0,1,0,1, stop high; STATUS[4]=1 after 160 cycles.
// - Write 5 bytes back-to-back with FIFO_DEPTH=4 while shifter idle -> first popped, 4 queued,
//   none dropped; 6th immediate write -> STATUS[3]=1, read STATUS clears it.
// - Drive 8'h3C serially on i_rx -> STATUS[0]=1, o_irqN=0; DATA read returns 8'h3C,
//   then STATUS[0]=0, o_irqN=1.
// - Receive 5 bytes without reading -> first 4 retained in order, STATUS[2]=1.
// - 3-cycle low glitch on i_rx -> no byte received; stop bit 0 -> byte discarded.
// - Assert i_reset mid TX frame and mid RX frame -> o_tx=1 next cycle, FIFOs empty, STATUS=8'h12.
// - Read with i_ioSelect=0 or address BASE_ADDR+2 -> o_dataNOE stays 1, no pop.

Source files
------------

// File: rtl/io_pkg.sv
// Shared I/O-window constants for the memory stage and the UART register map.
package io_pkg;

    // RAM address high byte that selects the I/O window
    localparam logic [7:0] IO_WINDOW_SEL = 8'hFE;

    localparam logic [7:0] UART_DATA   = 8'd0;
    localparam logic [7:0] UART_STATUS = 8'd1;

    localparam int unsigned ST_RX_NOT_EMPTY = 0;
    localparam int unsigned ST_TX_NOT_FULL  = 1;
    localparam int unsigned ST_RX_OVERRUN   = 2;
    localparam int unsigned ST_TX_OVERFLOW  = 3;
    localparam int unsigned ST_TX_IDLE      = 4;

    typedef struct packed {
        logic tx_idle;
        logic tx_overflow;
        logic rx_overrun;
        logic tx_not_full;
        logic rx_not_empty;
    } uart_status_t;

    function automatic logic [7:0] pack_status(input uart_status_t s);
        logic [7:0] v;
        v                  = '0;
        v[ST_RX_NOT_EMPTY] = s.rx_not_empty;
        v[ST_TX_NOT_FULL]  = s.tx_not_full;
        v[ST_RX_OVERRUN]   = s.rx_overrun;
        v[ST_TX_OVERFLOW]  = s.tx_overflow;
        v[ST_TX_IDLE]      = s.tx_idle;
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; push and pop may occur in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign head_o  = mem_q[rd_q[AW-1:0]];

    // A pop on a full FIFO frees the slot the simultaneous push lands in;
    // a pop on an empty FIFO is ignored even if a push arrives that cycle.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) begin
            wr_d = wr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART on the I/O window: DATA/STATUS registers, TX/RX FIFOs,
// serial shifters. Read data is driven through an active-low output enable.
module io_uart
    import io_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  BASE_ADDR  = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_ioSelect,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    input  logic [7:0] i_data,
    output logic [7:0] o_data,
    output logic       o_dataNOE,
    input  logic       i_rx,
    output logic       o_tx,
    output logic       o_irqN
);

    localparam int unsigned   CW          = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST    = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST   = CW'(CLK_DIV / 2 - 1);
    localparam logic [7:0]    DATA_ADDR   = BASE_ADDR + UART_DATA;
    localparam logic [7:0]    STATUS_ADDR = BASE_ADDR + UART_STATUS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic       hit, data_sel, rd_en, wr_en, status_rd;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] tx_head, rx_head, status;
    logic       tx_ovf_q, tx_ovf_d, rx_ovr_q, rx_ovr_d;

    logic [1:0]    tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_idx_q, tx_idx_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q, tx_d;

    logic [1:0]    rx_sync_q;
    logic          rx_s;
    logic [1:0]    rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_idx_q, rx_idx_d;
    logic [7:0]    rx_shift_q, rx_shift_d;

    // A simultaneous write suppresses the read, so the RX FIFO is never popped by it.
    assign hit       = i_ioSelect & ((i_ioAddress == DATA_ADDR) | (i_ioAddress == STATUS_ADDR));
    assign data_sel  = (i_ioAddress == DATA_ADDR);
    assign wr_en     = hit & ~i_ioNWE;
    assign rd_en     = hit & ~i_ioNOE & i_ioNWE;
    assign status_rd = rd_en & ~data_sel;

    assign tx_push = wr_en & data_sel;
    assign rx_pop  = rd_en & data_sel & ~rx_empty;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push_i  (tx_push),
        .data_i  (i_data),
        .pop_i   (tx_pop),
        .head_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push_i  (rx_push),
        .data_i  (rx_shift_q),
        .pop_i   (rx_pop),
        .head_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

    assign status = pack_status('{
        tx_idle:      tx_empty & (tx_state_q == S_IDLE),
        tx_overflow:  tx_ovf_q,
        rx_overrun:   rx_ovr_q,
        tx_not_full:  ~tx_full,
        rx_not_empty: ~rx_empty
    });

    always_comb begin
        o_data = '0;
        if (rd_en) begin
            if (data_sel) begin
                o_data = rx_empty ? 8'h00 : rx_head;
            end else begin
                o_data = status;
            end
        end
    end

    assign o_dataNOE = ~rd_en;
    assign o_irqN    = rx_empty;
    assign o_tx      = tx_q;

    // Set events win over the clear-on-STATUS-read in the same cycle.
    assign tx_ovf_d = (tx_push & tx_full & ~tx_pop) | (tx_ovf_q & ~status_rd);
    assign rx_ovr_d = (rx_push & rx_full & ~rx_pop) | (rx_ovr_q & ~status_rd);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            S_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_head;
                    tx_cnt_d   = '0;
                    tx_d       = 1'b0;
                    tx_state_d = S_START;
                end
            end
            S_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = S_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = S_STOP;
                    end else begin
                        tx_idx_d   = tx_idx_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_d = tx_head;
                        tx_d       = 1'b0;
                        tx_state_d = S_START;
                    end else begin
                        tx_state_d = S_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    assign rx_s = rx_sync_q[1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    rx_cnt_d   = '0;
                    rx_state_d = S_START;
                end
            end
            S_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_idx_d   = '0;
                    rx_state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s, rx_shift_q[7:1]};
                    if (rx_idx_q == 3'd7) begin
                        rx_state_d = S_STOP;
                    end else begin
                        rx_idx_d = rx_idx_q + 3'd1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            default: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_push    = rx_s;
                    rx_state_d = S_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            rx_sync_q  <= '1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
            rx_sync_q  <= {rx_sync_q[0], i_rx};
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovr_q   <= rx_ovr_d;
        end
    end

endmodule

// File: tb/tb_io_uart.sv
// Directed/randomised bench for io_uart: bus register access, TX framing, RX reception.
module tb_io_uart;

    localparam int unsigned CLK_DIV = 16;
    localparam int unsigned DEPTH   = 4;
    localparam logic [7:0]  A_DATA  = 8'h00;
    localparam logic [7:0]  A_STAT  = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       noe = 1'b1;
    logic       nwe = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] addr  = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       dnoe;
    logic       tx;
    logic       irqn;

    int checks   = 0;
    int failures = 0;
    int tx_frame_errs = 0;
    bit mon_en = 1'b0;
    logic [7:0] tx_got[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];

    always #5 clk = ~clk;

    io_uart #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(DEPTH), .BASE_ADDR(8'h00)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_ioSelect  (sel),
        .i_ioAddress (addr),
        .i_ioNOE     (noe),
        .i_ioNWE     (nwe),
        .i_data      (wdata),
        .o_data      (rdata),
        .o_dataNOE   (dnoe),
        .i_rx        (rx),
        .o_tx        (tx),
        .o_irqN      (irqn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] mk_status(input bit rxne, input bit txnf, input bit ovr,
                                             input bit ovf, input bit txidle);
        return {3'b000, txidle, ovf, ovr, txnf, rxne};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // All bus tasks start just after a negedge and return on the next negedge.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        sel = 1'b1; addr = a; wdata = d; nwe = 1'b0;
        @(negedge clk);
        sel = 1'b0; nwe = 1'b1;
    endtask

    task automatic bus_read(input logic [7:0] a, input logic s, output logic [7:0] d, output logic n);
        sel = s; addr = a; noe = 1'b0;
        #1;
        d = rdata;
        n = dnoe;
        @(negedge clk);
        sel = 1'b0; noe = 1'b1;
    endtask

    task automatic chk_status(input string tag, input logic [7:0] exp);
        logic [7:0] d;
        logic       n;
        bus_read(A_STAT, 1'b1, d, n);
        chk(tag, {24'b0, d}, {24'b0, exp});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CLK_DIV);
        end
        rx = stop;
        tick(CLK_DIV);
        rx = 1'b1;
    endtask

    task automatic wait_tx_idle(input int budget);
        logic [7:0] s;
        logic       n;
        int         k;
        s = '0;
        k = 0;
        while (s[4] !== 1'b1 && k < budget) begin
            bus_read(A_STAT, 1'b1, s, n);
            k++;
        end
        chk("tx_idle_wait", {31'b0, s[4]}, 32'd1);
    endtask

    // Passive line decoder: finds a start bit, samples every bit mid-cell.
    initial begin : tx_monitor
        logic [7:0] b;
        logic       ok;
        b = '0;
        forever begin
            @(negedge clk);
            if (mon_en && tx === 1'b0) begin
                ok = 1'b1;
                repeat (CLK_DIV / 2) @(negedge clk);
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (CLK_DIV) @(negedge clk);
                    b[i] = tx;
                end
                repeat (CLK_DIV) @(negedge clk);
                if (tx !== 1'b1) ok = 1'b0;
                if (mon_en) begin
                    if (ok) tx_got.push_back(b);
                    else tx_frame_errs++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [7:0] d;
        logic       n;
        logic [7:0] b;
        logic [7:0] b2;
        bit         ovr_m;
        int         lows;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx", {31'b0, tx}, 32'd1);
        chk("rst_dnoe", {31'b0, dnoe}, 32'd1);
        chk("rst_odata", {24'b0, rdata}, 32'd0);
        chk("rst_irqn", {31'b0, irqn}, 32'd1);
        chk_status("rst_status", 8'h12);
        mon_en = 1'b1;

        // Single TX byte with exact timing of every bit cell
        b = 8'hA5;
        bus_write(A_DATA, b);
        tx_exp.push_back(b);
        chk("tx_before_start", {31'b0, tx}, 32'd1);
        tick(1);
        chk("tx_start_first", {31'b0, tx}, 32'd0);
        tick(CLK_DIV / 2);
        chk("tx_start_mid", {31'b0, tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(CLK_DIV);
            chk($sformatf("tx_a5_bit%0d", i), {31'b0, tx}, {31'b0, b[i]});
        end
        tick(CLK_DIV);
        chk("tx_stop", {31'b0, tx}, 32'd1);
        tick(CLK_DIV / 2 - 1);
        bus_read(A_STAT, 1'b1, d, n);
        chk("status_last_stop_cycle", {24'b0, d}, {24'b0, mk_status(0, 1, 0, 0, 0)});
        chk("status_read_dnoe", {31'b0, n}, 32'd0);
        chk_status("status_tx_idle", mk_status(0, 1, 0, 0, 1));

        // Burst of DEPTH+1 writes while idle, then one overflowing write
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            bus_write(A_DATA, b);
            tx_exp.push_back(b);
        end
        bus_write(A_DATA, 8'($urandom));
        chk_status("status_tx_overflow", mk_status(0, 0, 0, 1, 0));
        chk_status("status_ovf_cleared", mk_status(0, 0, 0, 0, 0));
        wait_tx_idle((DEPTH + 2) * 10 * CLK_DIV);
        chk("tx_frame_errs", tx_frame_errs, 0);
        chk("tx_count", tx_got.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size(); i++) begin
            chk($sformatf("tx_byte%0d", i), {24'b0, (i < tx_got.size()) ? tx_got[i] : 8'hxx},
                {24'b0, tx_exp[i]});
        end

        // Single RX byte
        send_rx(8'h3C, 1'b1);
        chk("rx_irqn_low", {31'b0, irqn}, 32'd0);
        chk_status("status_rx_ne", mk_status(1, 1, 0, 0, 1));
        bus_read(A_DATA, 1'b1, d, n);
        chk("rx_data_3c", {24'b0, d}, 32'h3C);
        chk("rx_data_dnoe", {31'b0, n}, 32'd0);
        chk_status("status_rx_drained", mk_status(0, 1, 0, 0, 1));
        chk("rx_irqn_high", {31'b0, irqn}, 32'd1);

        // DEPTH+1 random RX bytes without reading
        ovr_m = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            send_rx(b, 1'b1);
            if (rx_exp.size() < DEPTH) rx_exp.push_back(b);
            else ovr_m = 1'b1;
            tick(int'($urandom_range(0, 5)));
        end
        chk_status("status_rx_overrun", mk_status(rx_exp.size() != 0, 1, ovr_m, 0, 1));
        while (rx_exp.size() != 0) begin
            bus_read(A_DATA, 1'b1, d, n);
            chk("rx_fifo_order", {24'b0, d}, {24'b0, rx_exp.pop_front()});
        end
        bus_read(A_DATA, 1'b1, d, n);
        chk("rx_empty_read", {24'b0, d}, 32'd0);
        chk("rx_empty_dnoe", {31'b0, n}, 32'd0);
        chk_status("status_after_drain", mk_status(0, 1, 0, 0, 1));

        // Start-bit glitch and a framing error both leave the FIFO empty
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(3 * CLK_DIV);
        chk_status("status_glitch", mk_status(0, 1, 0, 0, 1));
        send_rx(8'($urandom), 1'b0);
        tick(2 * CLK_DIV);
        chk_status("status_framing", mk_status(0, 1, 0, 0, 1));
        b2 = 8'($urandom);
        send_rx(b2, 1'b1);
        chk_status("status_rx_recover", mk_status(1, 1, 0, 0, 1));

        // Reads outside the decoded window neither drive the bus nor pop
        bus_read(A_DATA, 1'b0, d, n);
        chk("nosel_dnoe", {31'b0, n}, 32'd1);
        chk("nosel_odata", {24'b0, d}, 32'd0);
        bus_read(8'h02, 1'b1, d, n);
        chk("addr2_dnoe", {31'b0, n}, 32'd1);
        bus_read(A_DATA, 1'b1, d, n);
        chk("no_pop_data", {24'b0, d}, {24'b0, b2});

        // Reset in the middle of a TX frame and an RX frame
        mon_en = 1'b0;
        send_rx(8'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) bus_write(A_DATA, 8'($urandom));
        tick(40);
        rx = 1'b0;
        tick(30);
        rst = 1'b1;
        tick(1);
        chk("midrst_tx", {31'b0, tx}, 32'd1);
        chk("midrst_irqn", {31'b0, irqn}, 32'd1);
        chk("midrst_dnoe", {31'b0, dnoe}, 32'd1);
        tick(1);
        rst = 1'b0;
        rx = 1'b1;
        tick(2);
        chk_status("midrst_status", 8'h12);
        bus_read(A_DATA, 1'b1, d, n);
        chk("midrst_rx_empty", {24'b0, d}, 32'd0);
        lows = 0;
        for (int i = 0; i < 12 * CLK_DIV; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("midrst_tx_quiet", lows, 0);
        chk_status("midrst_status_final", 8'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
